// File: rtl/wb_rr_arbiter_wd_if.sv
// -----------------------------------------------------------------------------
// wb_rr_arbiter_wd_if
// Bundle of Wishbone signals around the round-robin arbiter: the flattened
// per-master request/response buses and the single shared slave port.
//
// Modports
//   slave  : the arbiter's view (it is the slave of all masters and drives
//            the shared slave port).
//   master : the surrounding environment's view (masters + downstream slave).
//
// Per-master vectors are flattened, master k occupies [k*W +: W].
// -----------------------------------------------------------------------------
interface wb_rr_arbiter_wd_if #(
    parameter int NUM_MASTERS = 2,
    parameter int DW          = 32,
    parameter int AW          = 32
);
    // master request side
    logic [AW*NUM_MASTERS-1:0] wbm_adr_i;
    logic [DW*NUM_MASTERS-1:0] wbm_dat_i;
    logic [4*NUM_MASTERS-1:0]  wbm_sel_i;
    logic [3*NUM_MASTERS-1:0]  wbm_cti_i;
    logic [2*NUM_MASTERS-1:0]  wbm_bte_i;
    logic [NUM_MASTERS-1:0]    wbm_we_i;
    logic [NUM_MASTERS-1:0]    wbm_cyc_i;
    logic [NUM_MASTERS-1:0]    wbm_stb_i;

    // master response side
    logic [DW*NUM_MASTERS-1:0] wbm_dat_o;
    logic [NUM_MASTERS-1:0]    wbm_ack_o;
    logic [NUM_MASTERS-1:0]    wbm_err_o;
    logic [NUM_MASTERS-1:0]    wbm_rty_o;

    // shared slave port, request side
    logic [AW-1:0]             wbs_adr_o;
    logic [DW-1:0]             wbs_dat_o;
    logic [3:0]                wbs_sel_o;
    logic                      wbs_we_o;
    logic                      wbs_cyc_o;
    logic                      wbs_stb_o;
    logic [2:0]                wbs_cti_o;
    logic [1:0]                wbs_bte_o;

    // shared slave port, response side
    logic [DW-1:0]             wbs_dat_i;
    logic                      wbs_ack_i;
    logic                      wbs_err_i;
    logic                      wbs_rty_i;

    modport slave (
        input  wbm_adr_i, wbm_dat_i, wbm_sel_i, wbm_cti_i, wbm_bte_i,
        input  wbm_we_i, wbm_cyc_i, wbm_stb_i,
        output wbm_dat_o, wbm_ack_o, wbm_err_o, wbm_rty_o,
        output wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o,
        output wbs_cyc_o, wbs_stb_o, wbs_cti_o, wbs_bte_o,
        input  wbs_dat_i, wbs_ack_i, wbs_err_i, wbs_rty_i
    );

    modport master (
        output wbm_adr_i, wbm_dat_i, wbm_sel_i, wbm_cti_i, wbm_bte_i,
        output wbm_we_i, wbm_cyc_i, wbm_stb_i,
        input  wbm_dat_o, wbm_ack_o, wbm_err_o, wbm_rty_o,
        input  wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o,
        input  wbs_cyc_o, wbs_stb_o, wbs_cti_o, wbs_bte_o,
        output wbs_dat_i, wbs_ack_i, wbs_err_i, wbs_rty_i
    );
endinterface

// File: rtl/wb_rr_arbiter_wd.sv
// -----------------------------------------------------------------------------
// wb_rr_arbiter_wd
// Round-robin Wishbone arbiter with a stall watchdog. Up to NUM_MASTERS
// masters share one slave. A master keeps the bus for as long as it holds
// cyc, so bursts and read-modify-write sequences are never split. If the
// slave leaves a strobed access unanswered for more than TIMEOUT cycles the
// transfer is terminated with err to the owning master and a timeout pulse.
//
// Ports
//   wb_clk_i   : clock, all state on the rising edge
//   wb_rst_ni  : asynchronous active-low reset
//   bus        : wb_rr_arbiter_wd_if.slave, master buses + shared slave port
//   grant_o    : registered one-hot grant, all zero while idle
//   timeout_o  : single-cycle pulse in the cycle a transfer is aborted
// -----------------------------------------------------------------------------
module wb_rr_arbiter_wd #(
    parameter int NUM_MASTERS = 2,
    parameter int DW          = 32,
    parameter int AW          = 32,
    parameter int TIMEOUT     = 255
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_ni,
    wb_rr_arbiter_wd_if.slave      bus,
    output logic [NUM_MASTERS-1:0] grant_o,
    output logic                   timeout_o
);

    localparam int          IW     = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam logic [15:0] TO_VAL = 16'(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_ABORT = 2'd2
    } state_t;

    state_t                 state_r;
    logic [NUM_MASTERS-1:0] grant_r;
    logic [IW-1:0]          gidx_r;
    logic [IW-1:0]          last_idx_r;
    logic [15:0]            wd_cnt_r;

    logic                   pick_found_s;
    logic [IW-1:0]          pick_idx_s;
    logic                   resp_s;
    logic                   gcyc_s;
    logic                   gstb_s;
    logic                   abort_s;
    int                     gsel_s;

    function automatic logic [NUM_MASTERS-1:0] idx_to_onehot(input logic [IW-1:0] idx);
        logic [NUM_MASTERS-1:0] oh;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            oh[i] = (IW'(i) == idx);
        end
        return oh;
    endfunction

    assign gsel_s  = int'(gidx_r);
    assign resp_s  = bus.wbs_ack_i | bus.wbs_err_i | bus.wbs_rty_i;
    assign gcyc_s  = bus.wbm_cyc_i[gidx_r];
    assign gstb_s  = bus.wbm_stb_i[gidx_r];
    // Abort only when the watchdog has already run out and the slave is still
    // silent in this cycle; a late response always wins over the watchdog.
    assign abort_s = (state_r == ST_GRANT) && gstb_s && !resp_s && (wd_cnt_r == TO_VAL);

    assign grant_o   = grant_r;
    assign timeout_o = abort_s;

    // Read data is broadcast; only the owner sees an ack that qualifies it.
    assign bus.wbm_dat_o = {NUM_MASTERS{bus.wbs_dat_i}};

    // Round-robin search: first requester upward from the previous winner, wrapping.
    always_comb begin
        pick_found_s = 1'b0;
        pick_idx_s   = '0;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            int   cand;
            logic hit;
            cand         = (int'(last_idx_r) + i) % NUM_MASTERS;
            hit          = !pick_found_s && bus.wbm_cyc_i[IW'(cand)];
            pick_idx_s   = hit ? IW'(cand) : pick_idx_s;
            pick_found_s = pick_found_s | hit;
        end
    end

    // Shared slave port mux and response steering to the owning master.
    always_comb begin
        bus.wbs_adr_o = '0;
        bus.wbs_dat_o = '0;
        bus.wbs_sel_o = 4'b0000;
        bus.wbs_we_o  = 1'b0;
        bus.wbs_cyc_o = 1'b0;
        bus.wbs_stb_o = 1'b0;
        bus.wbs_cti_o = 3'b000;
        bus.wbs_bte_o = 2'b00;
        bus.wbm_ack_o = '0;
        bus.wbm_err_o = '0;
        bus.wbm_rty_o = '0;
        if (state_r == ST_GRANT) begin
            bus.wbs_adr_o         = bus.wbm_adr_i[gsel_s*AW +: AW];
            bus.wbs_dat_o         = bus.wbm_dat_i[gsel_s*DW +: DW];
            bus.wbs_sel_o         = bus.wbm_sel_i[gsel_s*4 +: 4];
            bus.wbs_cti_o         = bus.wbm_cti_i[gsel_s*3 +: 3];
            bus.wbs_bte_o         = bus.wbm_bte_i[gsel_s*2 +: 2];
            bus.wbs_we_o          = bus.wbm_we_i[gidx_r];
            bus.wbs_cyc_o         = gcyc_s;
            bus.wbs_stb_o         = gstb_s;
            bus.wbm_ack_o[gidx_r] = bus.wbs_ack_i;
            bus.wbm_err_o[gidx_r] = bus.wbs_err_i | abort_s;
            bus.wbm_rty_o[gidx_r] = bus.wbs_rty_i;
        end else begin
            // Idle or aborting: slave port parked, no responses to anyone.
            bus.wbs_cyc_o = 1'b0;
            bus.wbs_stb_o = 1'b0;
        end
    end

    // Arbitration FSM, registered grant and stall watchdog.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_r    <= ST_IDLE;
            grant_r    <= '0;
            gidx_r     <= '0;
            last_idx_r <= IW'(NUM_MASTERS - 1);
            wd_cnt_r   <= 16'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (pick_found_s) begin
                        state_r    <= ST_GRANT;
                        gidx_r     <= pick_idx_s;
                        last_idx_r <= pick_idx_s;
                        grant_r    <= idx_to_onehot(pick_idx_s);
                        wd_cnt_r   <= 16'd0;
                    end else begin
                        state_r <= ST_IDLE;
                        grant_r <= '0;
                    end
                end
                ST_GRANT: begin
                    if (!gcyc_s) begin
                        // Owner released the bus; one idle cycle before the next grant.
                        state_r  <= ST_IDLE;
                        grant_r  <= '0;
                        wd_cnt_r <= 16'd0;
                    end else if (abort_s) begin
                        state_r <= ST_ABORT;
                    end else if (resp_s) begin
                        wd_cnt_r <= 16'd0;
                    end else if (gstb_s) begin
                        wd_cnt_r <= wd_cnt_r + 16'd1;
                    end else begin
                        wd_cnt_r <= wd_cnt_r;
                    end
                end
                ST_ABORT: begin
                    // Hold the bus parked until the aborted master lets go of cyc.
                    if (!gcyc_s) begin
                        state_r  <= ST_IDLE;
                        grant_r  <= '0;
                        wd_cnt_r <= 16'd0;
                    end else begin
                        state_r <= ST_ABORT;
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    grant_r  <= '0;
                    wd_cnt_r <= 16'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_rr_arbiter_wd.sv
// -----------------------------------------------------------------------------
// tb_wb_rr_arbiter_wd
// Randomised bench for the round-robin Wishbone arbiter with watchdog.
// A stimulus process plays three masters and a slave; each cycle it predicts
// the DUT outputs from a transaction-level model (owner, last winner, stall
// count) and queues them. A separate monitor pops and compares on the
// falling edge.
// -----------------------------------------------------------------------------
module tb_wb_rr_arbiter_wd;

    localparam int N  = 3;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int TO = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   grant;
    logic           timeout;

    wb_rr_arbiter_wd_if #(.NUM_MASTERS(N), .DW(DW), .AW(AW)) bus ();

    wb_rr_arbiter_wd #(.NUM_MASTERS(N), .DW(DW), .AW(AW), .TIMEOUT(TO)) dut (
        .wb_clk_i  (clk),
        .wb_rst_ni (rst_n),
        .bus       (bus),
        .grant_o   (grant),
        .timeout_o (timeout)
    );

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0]    grant;
        logic [N-1:0]    ack;
        logic [N-1:0]    err;
        logic [N-1:0]    rty;
        logic            tmo;
        logic [75:0]     sbus;
        logic [DW*N-1:0] mdat;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // master stimulus state
    logic [N-1:0] m_cyc, m_stb, m_we;
    logic [AW-1:0] m_adr [N];
    logic [DW-1:0] m_dat [N];
    logic [3:0]    m_sel [N];
    logic [2:0]    m_cti [N];
    logic [1:0]    m_bte [N];
    int            beats_left [N];
    int            beat_total [N];
    int            wait_cnt   [N];
    logic [N-1:0]  prev_ack, prev_err, prev_rty;

    // slave stimulus
    logic          s_ack, s_err, s_rty;
    logic [DW-1:0] s_dat;

    // reference model: who owns the bus, who won last, how long stalled
    int own;
    int last;
    int stall;
    bit aborted;

    int req_pct, max_beats, max_wait, slave_mode;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_bus();
        for (int k = 0; k < N; k++) begin
            bus.wbm_adr_i[k*AW +: AW] = m_adr[k];
            bus.wbm_dat_i[k*DW +: DW] = m_dat[k];
            bus.wbm_sel_i[k*4 +: 4]   = m_sel[k];
            bus.wbm_cti_i[k*3 +: 3]   = m_cti[k];
            bus.wbm_bte_i[k*2 +: 2]   = m_bte[k];
        end
        bus.wbm_we_i  = m_we;
        bus.wbm_cyc_i = m_cyc;
        bus.wbm_stb_i = m_stb;
        bus.wbs_dat_i = s_dat;
        bus.wbs_ack_i = s_ack;
        bus.wbs_err_i = s_err;
        bus.wbs_rty_i = s_rty;
    endtask

    task automatic model_reset();
        own      = -1;
        aborted  = 1'b0;
        last     = N - 1;
        stall    = 0;
        prev_ack = '0;
        prev_err = '0;
        prev_rty = '0;
        m_cyc    = '0;
        m_stb    = '0;
        m_we     = '0;
        for (int k = 0; k < N; k++) begin
            beats_left[k] = 0;
            beat_total[k] = 0;
            wait_cnt[k]   = 0;
            m_adr[k] = '0; m_dat[k] = '0; m_sel[k] = 4'h0; m_cti[k] = 3'b000; m_bte[k] = 2'b00;
        end
        s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0; s_dat = '0;
    endtask

    // One bus cycle: masters react, slave answers, expectation is queued.
    task automatic step();
        exp_t e;
        int   r;
        logic resp, tmo;
        bit   found;
        @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) begin
            if (beats_left[k] > 0) begin
                if (prev_ack[k]) begin
                    beats_left[k]--;
                    if (beats_left[k] == 0) wait_cnt[k] = $urandom_range(max_wait);
                end else if (prev_err[k] || prev_rty[k]) begin
                    beats_left[k] = 0;
                    wait_cnt[k]   = $urandom_range(max_wait);
                end
            end else if (wait_cnt[k] > 0) begin
                wait_cnt[k]--;
            end else if ($urandom_range(99) < req_pct) begin
                beats_left[k] = $urandom_range(max_beats, 1);
                beat_total[k] = beats_left[k];
            end
            m_cyc[k] = (beats_left[k] > 0);
            m_stb[k] = m_cyc[k];
            m_we[k]  = 1'($urandom_range(1));
            m_adr[k] = $urandom;
            m_dat[k] = $urandom;
            m_sel[k] = 4'($urandom_range(15));
            m_bte[k] = 2'($urandom_range(3));
            if (beat_total[k] <= 1) m_cti[k] = 3'b000;
            else if (beats_left[k] == 1) m_cti[k] = 3'b111;
            else m_cti[k] = 3'b010;
        end
        #1;
        r = $urandom_range(99);
        s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
        case (slave_mode)
            0: begin
                s_ack = (r < 40);
                s_err = (r >= 40 && r < 45);
                s_rty = (r >= 45 && r < 50);
            end
            1: s_ack = 1'b0;
            2: s_ack = (own >= 0 && !aborted && stall == TO);
            default: s_ack = 1'b1;
        endcase
        s_dat = $urandom;
        drive_bus();

        e.grant = '0; e.ack = '0; e.err = '0; e.rty = '0; e.tmo = 1'b0; e.sbus = '0;
        e.mdat  = {N{s_dat}};
        resp    = s_ack | s_err | s_rty;
        if (own < 0) begin
            found = 1'b0;
            for (int i = 1; i <= N; i++) begin
                if (!found && m_cyc[(last + i) % N]) begin
                    found   = 1'b1;
                    own     = (last + i) % N;
                end
            end
            if (found) begin
                last    = own;
                stall   = 0;
                aborted = 1'b0;
            end
        end else if (!aborted) begin
            tmo          = m_stb[own] && !resp && (stall == TO);
            e.grant[own] = 1'b1;
            e.sbus       = {m_cyc[own], m_stb[own], m_we[own], m_adr[own], m_dat[own],
                            m_sel[own], m_cti[own], m_bte[own]};
            e.ack[own]   = s_ack;
            e.err[own]   = s_err | tmo;
            e.rty[own]   = s_rty;
            e.tmo        = tmo;
            if (!m_cyc[own]) own = -1;
            else if (tmo) aborted = 1'b1;
            else if (resp) stall = 0;
            else if (m_stb[own]) stall++;
        end else begin
            e.grant[own] = 1'b1;
            if (!m_cyc[own]) begin
                own     = -1;
                aborted = 1'b0;
            end
        end
        prev_ack = e.ack;
        prev_err = e.err;
        prev_rty = e.rty;
        exp_q.push_back(e);
    endtask

    task automatic set_phase(input int pct, input int beats, input int wmax, input int mode);
        req_pct    = pct;
        max_beats  = beats;
        max_wait   = wmax;
        slave_mode = mode;
    endtask

    // Pull reset in the middle of a granted transfer, then release it.
    task automatic reset_mid();
        int n;
        n = 0;
        set_phase(100, 4, 0, 1);
        while (!(own >= 0 && !aborted) && n < 100) begin
            step();
            n++;
        end
        chk("reset_mid_grant_reached", 128'(n < 100), 128'(1));
        step();
        step();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_wbs_cyc", 128'(bus.wbs_cyc_o), 128'(0));
        chk("rst_async_grant",   128'(grant),         128'(0));
        chk("rst_async_err",     128'(bus.wbm_err_o), 128'(0));
        chk("rst_async_timeout", 128'(timeout),       128'(0));
        model_reset();
        drive_bus();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Monitor: compare every queued expectation on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("grant", 128'(grant), 128'(e.grant));
                chk("responses", 128'({bus.wbm_ack_o, bus.wbm_err_o, bus.wbm_rty_o}),
                    128'({e.ack, e.err, e.rty}));
                chk("timeout", 128'(timeout), 128'(e.tmo));
                chk("slave_bus", 128'({bus.wbs_cyc_o, bus.wbs_stb_o, bus.wbs_we_o, bus.wbs_adr_o,
                                       bus.wbs_dat_o, bus.wbs_sel_o, bus.wbs_cti_o, bus.wbs_bte_o}),
                    128'(e.sbus));
                chk("read_data", 128'(bus.wbm_dat_o), 128'(e.mdat));
            end
        end
    end

    // Stimulus sequence.
    initial begin
        rst_n = 1'b0;
        model_reset();
        set_phase(0, 1, 0, 3);
        drive_bus();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_grant",   128'(grant),         128'(0));
        chk("reset_wbs_cyc", 128'(bus.wbs_cyc_o), 128'(0));
        chk("reset_wbs_stb", 128'(bus.wbs_stb_o), 128'(0));
        chk("reset_timeout", 128'(timeout),       128'(0));
        chk("reset_resp", 128'({bus.wbm_ack_o, bus.wbm_err_o, bus.wbm_rty_o}), 128'(0));
        rst_n = 1'b1;

        // all masters hammering single beats, slave always acks: 0,1,2,0,...
        set_phase(100, 1, 0, 3);
        repeat (60) step();
        // mixed bursts with random slave waits, errors and retries
        set_phase(60, 4, 2, 0);
        repeat (1500) step();
        // dead slave: every tenure runs into the watchdog
        set_phase(100, 4, 1, 1);
        repeat (120) step();
        // slave answers exactly on the last permitted stall cycle
        set_phase(100, 4, 1, 2);
        repeat (200) step();
        // reset mid-burst, then all request so master 0 must win first
        reset_mid();
        set_phase(100, 1, 0, 3);
        repeat (40) step();
        set_phase(50, 4, 2, 0);
        repeat (500) step();

        @(negedge clk);
        #1;
        chk("queue_drained", 128'(exp_q.size()), 128'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_rr_arbiter_wd.md
WB_RR_ARBITER_WD -- requirements
Module: wb_rr_arbiter_wd

Interface
REQ-001 Parameter NUM_MASTERS, default 2, number of Wishbone masters (1..8).
REQ-002 Parameter DW, default 32, data width.
REQ-003 Parameter AW, default 32, address width.
REQ-004 Parameter TIMEOUT, default 255, maximum stalled cycles before abort (1..65535).
REQ-005 wb_clk_i  in  1  single clock; all state on rising edge.
REQ-006 wb_rst_ni  in  1  reset, asynchronous, active-low.
REQ-007 wbm_adr_i/wbm_dat_i  in  AW*NUM_MASTERS / DW*NUM_MASTERS  flattened master address/write data, master k at [k*W +: W].
REQ-008 wbm_sel_i  in  4*NUM_MASTERS; wbm_cti_i  in  3*NUM_MASTERS; wbm_bte_i  in  2*NUM_MASTERS; flattened likewise.
REQ-009 wbm_we_i/wbm_cyc_i/wbm_stb_i  in  NUM_MASTERS each  per-master strobes.
REQ-010 wbm_dat_o  out  DW*NUM_MASTERS  read data; every slice driven with wbs_dat_i.
REQ-011 wbm_ack_o/wbm_err_o/wbm_rty_o  out  NUM_MASTERS each  per-master responses.
REQ-012 wbs_adr_o AW, wbs_dat_o DW, wbs_sel_o 4, wbs_we_o 1, wbs_cyc_o 1, wbs_stb_o 1, wbs_cti_o 3, wbs_bte_o 2  out  shared slave port.
REQ-013 wbs_dat_i DW, wbs_ack_i 1, wbs_err_i 1, wbs_rty_i 1  in  slave responses.
REQ-014 grant_o  out  NUM_MASTERS  one-hot registered grant, 0 when idle.
REQ-015 timeout_o  out  1  one-cycle pulse when a transfer is aborted.

Function
REQ-016 FSM states IDLE, GRANT, ABORT; reset state IDLE.
REQ-017 IDLE: if any wbm_cyc_i high, next edge grants the first requesting master searched upward (with wrap) from last_idx+1; enter GRANT; last_idx <= winner.
REQ-018 IDLE with no requests: grant_o stays 0, last_idx unchanged.
REQ-019 GRANT: slave outputs combinationally mirror the granted master's signals; non-granted masters see ack/err/rty = 0.
REQ-020 GRANT: wbm_ack/err/rty_o[g] = wbs_ack/err/rty_i of the slave; no added latency.
REQ-021 Grant held while granted wbm_cyc_i high (bursts/RMW uninterrupted regardless of other requests).
REQ-022 Granted wbm_cyc_i low: next edge -> IDLE, grant_o = 0; exactly one idle cycle between grants.
REQ-023 Watchdog counter, 16 bits: cleared on grant and on any ack/err/rty; increments each GRANT cycle with wbs_stb_o high and no response.
REQ-024 Counter == TIMEOUT and no response in that cycle: wbm_err_o[g] asserted that cycle, timeout_o pulses, next edge -> ABORT.
REQ-025 ABORT: wbs_cyc_o = wbs_stb_o = 0, all master responses 0; granted master's cyc low -> next edge IDLE.
REQ-026 Slave response in same cycle counter reaches TIMEOUT: response wins, no abort, counter clears.
REQ-027 Outside GRANT: wbs_cyc_o = wbs_stb_o = wbs_we_o = 0, other slave outputs 0.
REQ-028 NUM_MASTERS = 1: same FSM; master 0 always wins.

Reset
REQ-029 wb_rst_ni low: immediately FSM = IDLE, grant_o = 0, last_idx = NUM_MASTERS-1 (master 0 wins first), counter = 0, timeout_o = 0, all cyc/stb/response outputs 0.
REQ-030 Reset asserted mid-transfer aborts silently: no err or timeout pulse; deassertion returns to IDLE behaviour next edge.

Verification
REQ-031 Masters 0,1 both raise cyc after reset -> grant_o = 01 one edge later; 0 drops cyc -> 00 for one cycle -> 10.
REQ-032 Three masters continuously requesting, 1-beat transfers -> grant order 0,1,2,0,1,2 with one idle cycle between.
REQ-033 Master 1 holds cyc across 4-beat burst (cti 010..111) while master 0 requests -> all 4 acks to master 1 before grant_o = 01.
REQ-034 TIMEOUT=8, slave never acks -> wbm_err_o[g] and timeout_o high on the 9th stb cycle, wbs_cyc_o = 0 next cycle, IDLE after master drops cyc.
REQ-035 TIMEOUT=8, ack on that same 9th cycle -> ack delivered, no err, no timeout_o.
REQ-036 wb_rst_ni pulsed low mid-burst -> wbs_cyc_o and grant_o 0 asynchronously, no err; after release master 0 granted first.
